// File: rtl/data_memory_dumper_if.sv
// Bus bundle for data_memory_dumper: dump request, memory debug port and byte stream.
// The slave modport is the dumper's view; master is the requester/memory/consumer side.
interface data_memory_dumper_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [ADDR_WIDTH-1:0] i_num_words;
    logic [ADDR_WIDTH-1:0] o_debug_addr;
    logic [DATA_WIDTH-1:0] i_debug_data;
    logic [7:0]            o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_base_addr, i_num_words, i_debug_data, i_tx_ready,
        output o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_base_addr, i_num_words, i_debug_data, i_tx_ready,
        input  o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done
    );
endinterface

// File: rtl/data_memory_dumper.sv
// Walks the data memory debug port over a word range and streams each word little-endian.
// Optional DATA_MEMORY_DUMPER_CHECKSUM_EN appends an XOR checksum byte after the data.
module data_memory_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input logic                 clk,
    input logic                 rst,
    data_memory_dumper_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        CAPTURE,
        SEND,
        NEXT,
        DONE
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    // State entered once the last word (or an empty request) has been handled
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [1:0]            byte_idx;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  busy;
    logic                  done;
    logic                  xfer;
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign xfer = tx_valid && bus.i_tx_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.i_start) state_nxt = (bus.i_num_words == '0) ? TAIL : ADDR;
            ADDR:    state_nxt = WAIT;
            WAIT:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND;
            SEND:    if (xfer && byte_idx == 2'd3) state_nxt = NEXT;
            NEXT:    state_nxt = (word_cnt == ADDR_WIDTH'(1)) ? TAIL : ADDR;
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
            CSUM:    if (xfer) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        tx_valid = (state == SEND);
        tx_data  = shift[7:0];
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
        if (state == CSUM) begin
            tx_valid = 1'b1;
            tx_data  = csum;
        end
`endif
    end

    // Byte lanes leave through shift[7:0]; the register drains to zero after a full word
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_addr <= '0;
            word_cnt   <= '0;
            shift      <= '0;
            byte_idx   <= '0;
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        debug_addr <= bus.i_base_addr;
                        word_cnt   <= bus.i_num_words;
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                CAPTURE: begin
                    shift    <= bus.i_debug_data;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (xfer) begin
                        shift    <= shift >> 8;
                        byte_idx <= byte_idx + 2'd1;
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
                        csum     <= csum ^ shift[7:0];
`endif
                    end
                end
                NEXT: begin
                    word_cnt <= word_cnt - ADDR_WIDTH'(1);
                    if (word_cnt != ADDR_WIDTH'(1)) debug_addr <= debug_addr + ADDR_WIDTH'(4);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_debug_addr = debug_addr;
    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_valid   = tx_valid;
    assign bus.o_busy       = busy;
    assign bus.o_done       = done;

endmodule

// File: tb/tb_data_memory_dumper.sv
// Directed bench for data_memory_dumper: byte stream, latency, back-pressure, wrap, abort.
module tb_data_memory_dumper;
    localparam int AW = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_dumper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    data_memory_dumper #(.DATA_WIDTH(DW), .MEM_SIZE(64), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory model with a registered debug read port
    logic [7:0] mem [64];
    function automatic logic [31:0] rd_word(input logic [5:0] a);
        return {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    endfunction
    always @(posedge clk) bus.i_debug_data <= rd_word(bus.o_debug_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int hold_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consumer ready: constant high, or the repeating 1-0-0-1 pattern
    logic       rdy_mode = 1'b0;
    logic [3:0] pat = 4'b1001;
    int         ph = 0;
    initial begin
        bus.i_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode) begin
                bus.i_tx_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                bus.i_tx_ready = 1'b1;
            end
        end
    end

    // Monitor, sampling mid-cycle
    logic [7:0]    q[$];
    logic [AW-1:0] addrs[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            first_valid_cyc = -1;
    int            start_cyc = 0;
    logic          hold_pend = 1'b0;
    logic [7:0]    hold_data = '0;
    logic          prev_busy = 1'b0;
    logic [AW-1:0] last_addr = '0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (hold_pend) begin
                    hold_checks++;
                    chk("hold_valid", bus.o_tx_valid, 1);
                    chk("hold_data", bus.o_tx_data, hold_data);
                end
                hold_pend = bus.o_tx_valid && !bus.i_tx_ready;
                hold_data = bus.o_tx_data;
                if (bus.o_tx_valid && bus.i_tx_ready) q.push_back(bus.o_tx_data);
                if (bus.o_tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (bus.o_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.o_busy && (!prev_busy || bus.o_debug_addr != last_addr))
                    addrs.push_back(bus.o_debug_addr);
                last_addr = bus.o_debug_addr;
                prev_busy = bus.o_busy;
            end else begin
                hold_pend = 1'b0;
                prev_busy = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        q.delete();
        addrs.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
    endtask

    task automatic start_dump(input logic [AW-1:0] base, input logic [AW-1:0] num);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_base_addr = base;
        bus.i_num_words = num;
        start_cyc       = cyc;
        @(negedge clk);
        bus.i_start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(tag, done_cnt != 0, 1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        logic [7:0] x;
        x = '0;
`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
        foreach (exp[i]) x ^= exp[i];
        exp.push_back(x);
`endif
        chk({tag, "_count"}, q.size(), exp.size());
        foreach (exp[i]) begin
            x = (i < q.size()) ? q[i] : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), x, exp[i]);
        end
    endtask

`ifdef DATA_MEMORY_DUMPER_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e1[$];
        logic [7:0] ew[$];
        logic [7:0] e4[$];
        logic [7:0] e0[$];
        int n;
        e1 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        ew = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        e4 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        e0.delete();

        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_num_words = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
        {mem[3], mem[2], mem[1], mem[0]}     = 32'h11223344;
        {mem[7], mem[6], mem[5], mem[4]}     = 32'hAABBCCDD;
        {mem[63], mem[62], mem[61], mem[60]} = 32'h55667788;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.o_tx_valid, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_addr", bus.o_debug_addr, 0);
        chk("rst_data", bus.o_tx_data, 0);
        rst = 1'b0;

        // Two words, ready always high
        clear_stats();
        start_dump(6'd0, 6'd2);
        wait_done("t1_done_seen", 60);
        repeat (3) @(negedge clk);
        chk("t1_first_valid_lat", first_valid_cyc - start_cyc, 4);
        chk("t1_done_lat", done_cyc - start_cyc, 17 + EXTRA);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_after", bus.o_busy, 0);
        chk("t1_addr_cnt", addrs.size(), 2);
        chk("t1_addr0", (addrs.size() > 0) ? addrs[0] : 6'h3F, 0);
        chk("t1_addr1", (addrs.size() > 1) ? addrs[1] : 6'h3F, 4);
        check_stream("t1", e1);

        // Same dump under back-pressure
        clear_stats();
        hold_checks = 0;
        rdy_mode = 1'b1;
        start_dump(6'd0, 6'd2);
        wait_done("t2_done_seen", 200);
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_stalls_seen", hold_checks > 0, 1);
        chk("t2_done_cnt", done_cnt, 1);
        check_stream("t2", e1);

        // Address wrap past the top of memory
        clear_stats();
        start_dump(6'd60, 6'd2);
        wait_done("t3_done_seen", 60);
        repeat (3) @(negedge clk);
        chk("t3_addr_cnt", addrs.size(), 2);
        chk("t3_addr0", (addrs.size() > 0) ? addrs[0] : 6'h3F, 60);
        chk("t3_addr1", (addrs.size() > 1) ? addrs[1] : 6'h3F, 0);
        check_stream("t3", ew);

        // Empty request
        clear_stats();
        start_dump(6'd8, 6'd0);
        wait_done("t4_done_seen", 20);
        repeat (3) @(negedge clk);
        chk("t4_done_lat", done_cyc - start_cyc, 1 + EXTRA);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_busy_after", bus.o_busy, 0);
        check_stream("t4", e0);

        // Second start while sending is ignored
        clear_stats();
        start_dump(6'd0, 6'd2);
        n = 0;
        while (q.size() < 2 && n < 40) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("t5_reached_send", q.size() >= 2, 1);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_base_addr = 6'd60;
        bus.i_num_words = 6'd5;
        @(negedge clk);
        bus.i_start     = 1'b0;
        wait_done("t5_done_seen", 60);
        repeat (20) @(negedge clk);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_busy_after", bus.o_busy, 0);
        check_stream("t5", e1);

        // Abort with reset after the third byte, then a fresh dump
        clear_stats();
        start_dump(6'd0, 6'd2);
        n = 0;
        while (q.size() < 3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_third_byte", q.size(), 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_valid_after_rst", bus.o_tx_valid, 0);
        chk("t6_busy_after_rst", bus.o_busy, 0);
        chk("t6_done_after_rst", bus.o_done, 0);
        repeat (20) @(negedge clk);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_no_more_bytes", q.size(), 3);
        clear_stats();
        start_dump(6'd4, 6'd1);
        wait_done("t6_restart_done_seen", 40);
        repeat (3) @(negedge clk);
        chk("t6_restart_done_cnt", done_cnt, 1);
        chk("t6_restart_addr", (addrs.size() > 0) ? addrs[0] : 6'h3F, 4);
        check_stream("t6", e4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
